inst_fetch_mem_ctrl: RTL and testbench

//  Instruction-side memory controller directly downstream of the IF stage's ROM port.
//  - Serves IF's word fetch requests (addr, r_enable) and returns a 32-bit instruction.
//  - Reads a byte-wide memory bus, 4 sequential byte reads per word, assembled little-endian.
//  - Holds the last fetched word; a repeat request to that address is a zero-wait hit.
//  - busy/done tell IF when to stall; flush aborts a fetch on a branch or jump redirect.

---
 rtl/inst_fetch_mem_ctrl.sv | 133 +++++++++++++
 tb/tb_inst_fetch_mem_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_mem_ctrl.sv
// Instruction-side memory controller: turns IF word fetches into four byte reads,
// assembles them little-endian and keeps the last word for zero-wait repeat hits.
module inst_fetch_mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r_enable_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              flush_i,
  output logic [31:0]       data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_re_o,
  input  logic [7:0]        mem_data_i,
  input  logic              mem_valid_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] hold_addr;
  logic              hold_valid;
  logic [ADDR_W-1:0] base;
  logic [1:0]        idx;
  logic [23:0]       asm_buf;

  logic hit;
  logic miss_req;
  logic byte_done;

  // Only the word part of the address matters; the shifts drop the byte offset.
  assign hit       = hold_valid && ((addr_i >> 2) == (hold_addr >> 2));
  assign miss_req  = r_enable_i && !hit && !flush_i;
  assign byte_done = (state == WAIT) && mem_valid_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (miss_req) begin
          state_next = REQ;
        end
      end
      REQ: begin
        state_next = flush_i ? IDLE : WAIT;
      end
      WAIT: begin
        // A flush with the byte already arriving simply drops it; otherwise the
        // outstanding read must be drained before memory can be used again.
        if (mem_valid_i) begin
          if (flush_i || (idx == 2'd3)) begin
            state_next = IDLE;
          end else begin
            state_next = REQ;
          end
        end else if (flush_i) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_valid_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o     = 1'b0;
    mem_re_o   = 1'b0;
    mem_addr_o = '0;
    if (!rst) begin
      busy_o = (state != IDLE) || miss_req;
      if (state == REQ) begin
        mem_addr_o = base | ADDR_W'(idx);
        mem_re_o   = !flush_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_o     <= '0;
      done_o     <= 1'b0;
      hold_addr  <= '0;
      hold_valid <= 1'b0;
      base       <= '0;
      idx        <= 2'd0;
      asm_buf    <= '0;
    end else begin
      done_o <= 1'b0;
      if ((state == IDLE) && miss_req) begin
        base <= addr_i & WORD_MASK;
        idx  <= 2'd0;
      end
      if (byte_done && !flush_i) begin
        if (idx == 2'd3) begin
          // The top byte goes straight from the bus into the word.
          data_o     <= {mem_data_i, asm_buf};
          hold_addr  <= base;
          hold_valid <= 1'b1;
          done_o     <= 1'b1;
        end else begin
          case (idx)
            2'd0:    asm_buf[7:0]   <= mem_data_i;
            2'd1:    asm_buf[15:8]  <= mem_data_i;
            2'd2:    asm_buf[23:16] <= mem_data_i;
            default: ;
          endcase
          idx <= idx + 2'd1;
        end
      end
      if (flush_i) begin
        hold_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_mem_ctrl.sv
// Directed bench for inst_fetch_mem_ctrl with a byte memory model of adjustable latency.
module tb_inst_fetch_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        r_enable_i;
  logic [31:0] addr_i;
  logic        flush_i;
  logic [31:0] data_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] mem_addr_o;
  logic        mem_re_o;
  logic [7:0]  mem_data_i;
  logic        mem_valid_i;

  int total = 0;
  int bad = 0;

  logic [7:0]  mem [0:511];
  int          lat = 1;
  int          pending = 0;
  int          cnt = 0;
  int          overlap = 0;
  logic [31:0] paddr;
  logic [31:0] re_log [$];

  inst_fetch_mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .r_enable_i(r_enable_i),
    .addr_i(addr_i),
    .flush_i(flush_i),
    .data_o(data_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .mem_addr_o(mem_addr_o),
    .mem_re_o(mem_re_o),
    .mem_data_i(mem_data_i),
    .mem_valid_i(mem_valid_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers lat cycles after each strobe; a strobe while busy is an overlap.
  initial begin
    mem_valid_i = 1'b0;
    mem_data_i  = 8'h00;
    forever begin
      @(negedge clk);
      mem_valid_i = 1'b0;
      if (pending != 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          mem_valid_i = 1'b1;
          mem_data_i  = mem[paddr[8:0]];
          pending     = 0;
        end
      end
      if (mem_re_o) begin
        if (pending != 0) overlap = overlap + 1;
        pending = 1;
        cnt     = lat;
        paddr   = mem_addr_o;
        re_log.push_back(mem_addr_o);
      end
    end
  end

  task automatic run_miss_fetch(input logic [31:0] a, input int lat_in,
                                input logic [31:0] exp_word, input int exp_busy);
    int busy_cnt = 0;
    int done_cnt = 0;
    logic done_at_fall = 1'b0;
    logic fell = 1'b0;
    lat = lat_in;
    overlap = 0;
    re_log.delete();
    @(posedge clk); #1;
    r_enable_i = 1'b1; addr_i = a; flush_i = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_o) done_cnt++;
      if (!busy_o) begin
        done_at_fall = done_o;
        fell = 1'b1;
        break;
      end
      busy_cnt++;
    end
    total++;
    if (fell !== 1'b1) begin bad++; $display("[TB] FAIL fetch_timeout: got busy stuck want release"); end
    total++;
    if (busy_cnt !== exp_busy) begin bad++; $display("[TB] FAIL busy_cycles: got %0d want %0d", busy_cnt, exp_busy); end
    total++;
    if (done_cnt !== 1) begin bad++; $display("[TB] FAIL done_pulses: got %0d want 1", done_cnt); end
    total++;
    if (done_at_fall !== 1'b1) begin bad++; $display("[TB] FAIL done_at_fall: got %0b want 1", done_at_fall); end
    total++;
    if (data_o !== exp_word) begin bad++; $display("[TB] FAIL fetch_word: got %08h want %08h", data_o, exp_word); end
    total++;
    if (re_log.size() !== 4) begin bad++; $display("[TB] FAIL read_count: got %0d want 4", re_log.size()); end
    for (int k = 0; k < 4 && k < re_log.size(); k++) begin
      total++;
      if (re_log[k] !== ((a & 32'hFFFF_FFFC) + 32'(k))) begin
        bad++; $display("[TB] FAIL read_addr%0d: got %08h want %08h", k, re_log[k], (a & 32'hFFFF_FFFC) + 32'(k));
      end
    end
    total++;
    if (overlap !== 0) begin bad++; $display("[TB] FAIL outstanding: got %0d overlaps want 0", overlap); end
    @(posedge clk); #1;
    r_enable_i = 1'b0;
  endtask

  task automatic wait_re(input logic [31:0] a, output logic found);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_re_o && mem_addr_o == a) begin
        found = 1'b1;
        break;
      end
    end
    total++;
    if (found !== 1'b1) begin bad++; $display("[TB] FAIL wait_read_%08h: got none want strobe", a); end
  endtask

  task automatic test_reset();
    rst = 1'b1; r_enable_i = 1'b1; addr_i = 32'h100; flush_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({data_o, done_o, busy_o, mem_re_o, mem_addr_o} !== 67'd0) begin
      bad++; $display("[TB] FAIL reset_outputs: got data=%08h done=%0b busy=%0b re=%0b addr=%08h want all 0",
                      data_o, done_o, busy_o, mem_re_o, mem_addr_o);
    end
    @(posedge clk); #1;
    rst = 1'b0; r_enable_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (busy_o !== 1'b0 || mem_re_o !== 1'b0) begin
        bad++; $display("[TB] FAIL idle_no_request: got busy=%0b re=%0b want 0 0", busy_o, mem_re_o);
      end
    end
  endtask

  task automatic test_miss_fetch();
    run_miss_fetch(32'h100, 1, 32'h0010_0513, 9);
  endtask

  task automatic test_hit();
    re_log.delete();
    @(posedge clk); #1;
    r_enable_i = 1'b1; addr_i = 32'h102;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || mem_re_o !== 1'b0 || data_o !== 32'h0010_0513) begin
        bad++; $display("[TB] FAIL hit: got busy=%0b done=%0b re=%0b data=%08h want 0 0 0 00100513",
                        busy_o, done_o, mem_re_o, data_o);
      end
    end
    @(posedge clk); #1;
    r_enable_i = 1'b0;
    total++;
    if (re_log.size() !== 0) begin bad++; $display("[TB] FAIL hit_reads: got %0d want 0", re_log.size()); end
  endtask

  task automatic test_flush_drain();
    logic found;
    int dones = 0;
    lat = 3;
    re_log.delete();
    @(posedge clk); #1;
    r_enable_i = 1'b1; addr_i = 32'h104;
    wait_re(32'h105, found);
    @(posedge clk); #1;
    flush_i = 1'b1; r_enable_i = 1'b0;
    @(negedge clk);
    if (done_o) dones++;
    total++;
    if (busy_o !== 1'b1) begin bad++; $display("[TB] FAIL flush_wait_busy: got %0b want 1", busy_o); end
    @(posedge clk); #1;
    flush_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done_o) dones++;
      total++;
      if (busy_o !== 1'b1) begin bad++; $display("[TB] FAIL drain_busy: got %0b want 1", busy_o); end
    end
    @(negedge clk);
    if (done_o) dones++;
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL drain_exit: got busy=%0b want 0", busy_o); end
    total++;
    if (dones !== 0) begin bad++; $display("[TB] FAIL drain_done: got %0d pulses want 0", dones); end
    total++;
    if (re_log.size() !== 2) begin bad++; $display("[TB] FAIL drain_reads: got %0d want 2", re_log.size()); end
    total++;
    if (data_o !== 32'h0010_0513) begin bad++; $display("[TB] FAIL drain_data: got %08h want 00100513", data_o); end
    // Flush dropped the held word, so the previous hit address must miss now.
    run_miss_fetch(32'h100, 1, 32'h0010_0513, 9);
  endtask

  task automatic test_flush_last_byte();
    logic found;
    lat = 1;
    @(posedge clk); #1;
    r_enable_i = 1'b1; addr_i = 32'h104;
    wait_re(32'h107, found);
    @(posedge clk); #1;
    flush_i = 1'b1; r_enable_i = 1'b0;
    @(negedge clk);
    total++;
    if (done_o !== 1'b0) begin bad++; $display("[TB] FAIL flush_last_done_a: got %0b want 0", done_o); end
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    total++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("[TB] FAIL flush_last_idle: got done=%0b busy=%0b want 0 0", done_o, busy_o);
    end
    total++;
    if (data_o !== 32'h0010_0513) begin bad++; $display("[TB] FAIL flush_last_data: got %08h want 00100513", data_o); end
  endtask

  task automatic test_reset_mid_fetch();
    logic found;
    lat = 1;
    @(posedge clk); #1;
    r_enable_i = 1'b1; addr_i = 32'h100;
    @(negedge clk);
    total++;
    if (busy_o !== 1'b1) begin bad++; $display("[TB] FAIL miss_after_flush: got busy=%0b want 1", busy_o); end
    wait_re(32'h102, found);
    #1 rst = 1'b1;
    @(negedge clk);
    total++;
    if ({data_o, done_o, busy_o, mem_re_o, mem_addr_o} !== 67'd0) begin
      bad++; $display("[TB] FAIL mid_reset: got data=%08h done=%0b busy=%0b re=%0b addr=%08h want all 0",
                      data_o, done_o, busy_o, mem_re_o, mem_addr_o);
    end
    @(posedge clk); #1;
    rst = 1'b0; r_enable_i = 1'b0;
    @(negedge clk);
    total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      bad++; $display("[TB] FAIL post_reset_idle: got busy=%0b done=%0b want 0 0", busy_o, done_o);
    end
    run_miss_fetch(32'h104, 1, 32'h0020_0593, 9);
  endtask

  task automatic test_slow_memory();
    run_miss_fetch(32'h100, 5, 32'h0010_0513, 25);
  endtask

  initial begin
    rst = 1'b1; r_enable_i = 1'b0; addr_i = 32'h0; flush_i = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = 8'hEE;
    mem[9'h100] = 8'h13; mem[9'h101] = 8'h05; mem[9'h102] = 8'h10; mem[9'h103] = 8'h00;
    mem[9'h104] = 8'h93; mem[9'h105] = 8'h05; mem[9'h106] = 8'h20; mem[9'h107] = 8'h00;
    test_reset();
    test_miss_fetch();
    test_hit();
    test_flush_drain();
    test_flush_last_byte();
    test_reset_mid_fetch();
    test_slow_memory();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
